// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM states, default width,
// and the bit-counter width helper.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 4;

   // Bits needed to index operand bit positions 0..width-1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/serial_sub_fs_cell.sv
// Combinational one-bit full subtractor: d = a - b - bin, with borrow-out.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   // Difference bit and borrow generated/propagated through this position.
   always_comb begin
      d    = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor: D = A - B - Bin, one bit per clock through a single
// full-subtractor cell. start/busy/done framing; result held between ops.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] D,
   output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CW = cnt_width(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic             load_c;
   logic             last_c;

   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res_sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic             cell_d;
   logic             cell_bout;

   assign last_c = (cnt == CW'(WIDTH - 1));

   // The one arithmetic cell: consumes the LSB of each operand shift register.
   fs_cell u_fs_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (cell_d),
      .bout (cell_bout)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic; a start is only accepted from IDLE or DONE.
   always_comb begin
      state_nx = state;
      load_c   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = RUN;
               load_c   = 1'b1;
            end
         end
         RUN: begin
            if (last_c) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_nx = RUN;
               load_c   = 1'b1;
            end else begin
               state_nx = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Registered handshake flags derived from the upcoming state.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_nx == RUN);
         done <= (state_nx == DONE);
      end
   end

   // Serial datapath: load on accept, shift one bit per RUN cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         br     <= 1'b0;
         cnt    <= '0;
      end else if (load_c) begin
         a_sr   <= A;
         b_sr   <= B;
         res_sr <= '0;
         br     <= Bin;
         cnt    <= '0;
      end else if (state == RUN) begin
         a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
         b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
         res_sr <= {cell_d, res_sr[WIDTH-1:1]};
         br     <= cell_bout;
         cnt    <= cnt + CW'(1);
      end
   end

   // Result registers update only on the final RUN cycle (entry to DONE).
   always_ff @(posedge clk) begin
      if (rst) begin
         D    <= '0;
         Bout <= 1'b0;
      end else if ((state == RUN) && last_c) begin
         D    <= {cell_d, res_sr[WIDTH-1:1]};
         Bout <= cell_bout;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   // Signed overflow: borrow into the MSB differs from borrow out of it.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else if ((state == RUN) && last_c) begin
         ovf <= br ^ cell_bout;
      end
   end
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub (WIDTH=4): stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_serial_sub;

   localparam int unsigned W = 4;

   typedef struct packed {
      logic [W-1:0] d;
      logic         bout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bin;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         Bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int   total = 0;
   int   bad   = 0;
   exp_t sb_q[$];

   serial_sub #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h want=0x%0h @%0t", name, act, exp, $time);
      end
   endtask

   // Reference model for directed-free operands.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
      exp_t       e;
      logic [W:0] diff;
      int         sd;
      diff   = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
      e.d    = diff[W-1:0];
      e.bout = diff[W];
      sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
      e.ovf  = (sd < -8) || (sd > 7);
      return e;
   endfunction

   // Monitor: every done pulse must match the oldest expected result.
   always @(negedge clk) begin
      if (busy && done) chk("busy_done_overlap", 32'(1), 32'(0));
      if (done) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_done", 32'(1), 32'(0));
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("D", 32'(D), 32'(e.d));
            chk("Bout", 32'(Bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
         end
      end
   end

   // Drive an accepted start at the current negedge; optionally push expectation.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic push, input exp_t e);
      A     = a;
      B     = b;
      Bin   = bin;
      start = 1'b1;
      if (push) sb_q.push_back(e);
   endtask

   // Follow one operation: busy for W cycles with D held, then done.
   task automatic track(input logic disturb, input logic [W-1:0] prev_d);
      for (int i = 1; i <= W; i++) begin
         @(negedge clk);
         start = (disturb && i < W) ? 1'($urandom) : 1'b0;
         if (disturb) begin
            A   = W'($urandom);
            B   = W'($urandom);
            Bin = 1'($urandom);
         end
         chk($sformatf("busy_c%0d", i), 32'(busy), 32'(1));
         chk($sformatf("held_D_c%0d", i), 32'(D), 32'(prev_d));
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_pulse", 32'(done), 32'(1));
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                     input exp_t e, input logic disturb);
      logic [W-1:0] prev;
      @(negedge clk);
      prev = D;
      issue(a, b, bin, 1'b1, e);
      track(disturb, prev);
   endtask

   initial begin
      exp_t e;
      int   no_done;
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      Bin   = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_D", 32'(D), 32'(0));
      chk("rst_Bout", 32'(Bout), 32'(0));
      rst = 1'b0;

      // Directed vectors: {d, bout, ovf} hand-computed.
      op(4'd9, 4'd3, 1'b0, '{d: 4'h6, bout: 1'b0, ovf: 1'b1}, 1'b0);
      op(4'd3, 4'd9, 1'b0, '{d: 4'hA, bout: 1'b1, ovf: 1'b1}, 1'b0);
      op(4'd0, 4'd0, 1'b1, '{d: 4'hF, bout: 1'b1, ovf: 1'b0}, 1'b0);
      op(4'd5, 4'd5, 1'b0, '{d: 4'h0, bout: 1'b0, ovf: 1'b0}, 1'b0);
      op(4'd7, 4'hF, 1'b0, '{d: 4'h8, bout: 1'b1, ovf: 1'b1}, 1'b0);
      op(4'd2, 4'd1, 1'b0, '{d: 4'h1, bout: 1'b0, ovf: 1'b0}, 1'b0);
      // start pulses and operand changes during RUN must not matter.
      op(4'd12, 4'd5, 1'b1, '{d: 4'h6, bout: 1'b0, ovf: 1'b1}, 1'b1);

      // Back-to-back: new start issued in the DONE cycle of 9-3.
      op(4'd9, 4'd3, 1'b0, '{d: 4'h6, bout: 1'b0, ovf: 1'b1}, 1'b0);
      issue(4'hF, 4'd1, 1'b0, 1'b1, '{d: 4'hE, bout: 1'b0, ovf: 1'b0});
      track(1'b0, 4'h6);

      // Abort mid-RUN: no done, outputs cleared the cycle after reset.
      @(negedge clk);
      issue(4'd1, 4'd2, 1'b0, 1'b0, '0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'(0));
      chk("abort_D", 32'(D), 32'(0));
      chk("abort_Bout", 32'(Bout), 32'(0));
      no_done = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) no_done++;
      end
      chk("abort_no_done", 32'(no_done), 32'(0));

      // Random operands against the reference model.
      for (int n = 0; n < 1000; n++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rc;
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         e  = model(ra, rb, rc);
         op(ra, rb, rc, e, 1'b0);
      end

      @(negedge clk);
      chk("scoreboard_empty", 32'(sb_q.size()), 32'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
